// File: rtl/jt900h_bankregs_pkg.sv
// Shared codes for the 900H banked register file:
// access sizes, bank-pointer ops, pointer slots, clear states.
package jt900h_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;

  localparam logic [1:0] RFP_NONE = 2'd0;
  localparam logic [1:0] RFP_INCF = 2'd1;
  localparam logic [1:0] RFP_DECF = 2'd2;
  localparam logic [1:0] RFP_LD   = 2'd3;

  localparam logic [1:0] XIX = 2'd0;
  localparam logic [1:0] XIY = 2'd1;
  localparam logic [1:0] XIZ = 2'd2;
  localparam logic [1:0] XSP = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_st_t;

  // pointer slots live after all bank accumulators
  function automatic int ent_idx(
    input logic       ptr,
    input int         bank,
    input logic [1:0] r,
    input int         banks
  );
    return ptr ? banks*4 + int'(r) : bank*4 + int'(r);
  endfunction

endpackage

// File: rtl/jt900h_bankregs_rdmux.sv
// One read port: address decode, pending-write bypass,
// lane shift and sign/zero extension.
module jt900h_bankregs_rdmux
  import jt900h_pkg::*;
#(
  parameter int BANKS = 4,
  localparam int BW   = $clog2(BANKS),
  localparam int IW   = BW + 2,
  localparam int AW   = IW + 3,
  localparam int NENT = BANKS*4 + 4,
  localparam int EW   = $clog2(NENT)
) (
  input  logic [AW-1:0] a,
  input  logic          rel,
  input  logic [1:0]    size,
  input  logic          sex,
  input  logic [BW-1:0] rfp,
  input  logic          busy,
  input  logic [31:0]   regs [NENT],
  input  logic          pend_v,
  input  logic [EW-1:0] pend_e,
  input  logic [3:0]    pend_be,
  input  logic [31:0]   pend_d,
  output logic [31:0]   d
);

  logic [BW-1:0] bank;
  logic [EW-1:0] ent;
  logic [31:0]   raw;
  logic [31:0]   sh;

  assign bank = rel ? rfp : a[AW-2 -: BW];
  assign ent  = EW'(ent_idx(a[AW-1], int'(bank), a[3:2], BANKS));

  always_comb begin
    raw = regs[ent];
    for (int b = 0; b < 4; b++)
      if (pend_v && pend_e == ent && pend_be[b])
        raw[8*b +: 8] = pend_d[8*b +: 8];
    sh = raw;
    d  = raw;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        sh = raw >> {a[1:0], 3'b000};
        d  = {{24{sex & sh[7]}}, sh[7:0]};
      end
      (size == SZ_WORD): begin
        sh = raw >> {a[1], 4'b0000};
        d  = {{16{sex & sh[15]}}, sh[15:0]};
      end
      default: d = raw;
    endcase
    if (busy) d = '0;
  end

endmodule

// File: rtl/jt900h_bankregs.sv
// Banked 900H register file: registered write stage,
// bank pointer and post-reset clear sequencer.
module jt900h_bankregs
  import jt900h_pkg::*;
#(
  parameter int BANKS = 4,
  parameter int NRD   = 2,
  localparam int BW   = $clog2(BANKS),
  localparam int IW   = BW + 2,
  localparam int AW   = IW + 3,
  localparam int NENT = BANKS*4 + 4,
  localparam int EW   = $clog2(NENT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            clr,
  output logic            busy,
  output logic [BW-1:0]   rfp,
  input  logic [1:0]      rfp_op,
  input  logic [BW-1:0]   rfp_in,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic            wrel,
  input  logic [1:0]      wsize,
  input  logic [31:0]     wd,
  input  logic [NRD*AW-1:0] ra,
  input  logic [NRD-1:0]  rrel,
  input  logic [NRD*2-1:0] rsize,
  input  logic [NRD-1:0]  rsex,
  output logic [NRD*32-1:0] rd,
  output logic            wr_drop
);

  logic [31:0]   regs [NENT];
  clr_st_t       st, st_nx;
  logic [EW-1:0] cnt, cnt_nx;

  logic          pend_v;
  logic [EW-1:0] pend_e;
  logic [3:0]    pend_be;
  logic [31:0]   pend_d;

  logic [BW-1:0] wbank;
  logic [EW-1:0] went;
  logic [3:0]    wbe;
  logic [31:0]   wdat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_CLEAR;
      cnt <= '0;
    end else if (cen) begin
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    unique case (st)
      ST_IDLE: begin
        if (clr) begin
          st_nx  = ST_CLEAR;
          cnt_nx = '0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          cnt_nx = '0;
        end else if (cnt == EW'(NENT-1)) begin
          st_nx  = ST_IDLE;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + EW'(1);
        end
      end
    endcase
  end

  always_comb busy = (st == ST_CLEAR);

  assign wbank = wrel ? rfp : wa[AW-2 -: BW];
  assign went  = EW'(ent_idx(wa[AW-1], int'(wbank), wa[3:2], BANKS));

  always_comb begin
    wbe  = 4'b1111;
    wdat = wd;
    unique case (1'b1)
      (wsize == SZ_BYTE): begin
        wbe  = 4'b0001 << wa[1:0];
        wdat = {24'd0, wd[7:0]} << {wa[1:0], 3'b000};
      end
      (wsize == SZ_WORD): begin
        wbe  = wa[1] ? 4'b1100 : 4'b0011;
        wdat = wa[1] ? {wd[15:0], 16'd0} : {16'd0, wd[15:0]};
      end
      default: ;
    endcase
  end

  // a write alongside clr is dropped with the rest of the pending state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v  <= 1'b0;
      pend_e  <= '0;
      pend_be <= '0;
      pend_d  <= '0;
      rfp     <= '0;
      wr_drop <= 1'b0;
    end else if (cen) begin
      wr_drop <= we & busy;
      pend_v  <= we & ~busy & ~clr;
      if (we && !busy) begin
        pend_e  <= went;
        pend_be <= wbe;
        pend_d  <= wdat;
      end
      unique case (1'b1)
        (rfp_op == RFP_INCF): rfp <= rfp + BW'(1);
        (rfp_op == RFP_DECF): rfp <= rfp - BW'(1);
        (rfp_op == RFP_LD):   rfp <= rfp_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cen) begin
      if (busy) begin
        regs[cnt] <= '0;
      end else if (pend_v && !clr) begin
        for (int b = 0; b < 4; b++)
          if (pend_be[b])
            regs[pend_e][8*b +: 8] <= pend_d[8*b +: 8];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    jt900h_bankregs_rdmux #(
      .BANKS(BANKS)
    ) u_rd (
      .a      (ra[i*AW +: AW]),
      .rel    (rrel[i]),
      .size   (rsize[2*i +: 2]),
      .sex    (rsex[i]),
      .rfp    (rfp),
      .busy   (busy),
      .regs   (regs),
      .pend_v (pend_v),
      .pend_e (pend_e),
      .pend_be(pend_be),
      .pend_d (pend_d),
      .d      (rd[32*i +: 32])
    );
  end

endmodule

// File: tb/tb_jt900h_bankregs.sv
// Bench for jt900h_bankregs: read table plus scoreboarded
// sequences for bypass, bank pointer, clear and reset.
module tb_jt900h_bankregs;
  import jt900h_pkg::*;

  localparam int AW  = 7;
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic rst_n, cen, clr, busy, we, wrel, wr_drop;
  logic [1:0] rfp, rfp_in, rfp_op, wsize;
  logic [AW-1:0] wa;
  logic [31:0] wd;
  logic [NRD*AW-1:0] ra;
  logic [NRD-1:0] rrel, rsex;
  logic [NRD*2-1:0] rsize;
  logic [NRD*32-1:0] rd;

  always #5 clk = ~clk;

  jt900h_bankregs #(.BANKS(4), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr(clr),
    .busy(busy), .rfp(rfp), .rfp_op(rfp_op),
    .rfp_in(rfp_in), .we(we), .wa(wa), .wrel(wrel),
    .wsize(wsize), .wd(wd), .ra(ra), .rrel(rrel),
    .rsize(rsize), .rsex(rsex), .rd(rd),
    .wr_drop(wr_drop)
  );

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [1:0]    sz;
    logic          sx;
    logic [31:0]   exp;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[15];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [AW-1:0] mk(
    input logic p, input logic [1:0] b,
    input logic [1:0] r, input logic [1:0] l);
    return {p, b, r, l};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input int p, input logic [AW-1:0] a,
                        input logic rel, input logic [1:0] sz,
                        input logic sx, input logic [31:0] e,
                        input string nm);
    exp_t x;
    ra[p*AW +: AW] = a;
    rrel[p] = rel;
    rsize[2*p +: 2] = sz;
    rsex[p] = sx;
    x.port = p;
    x.exp = e;
    x.nm = nm;
    sbq.push_back(x);
  endtask

  task automatic rd_chk();
    exp_t x;
    @(negedge clk);
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk(x.nm, rd[x.port*32 +: 32], x.exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic rel,
                    input logic [1:0] sz, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wrel = rel;
    wsize = sz;
    wd = d;
  endtask

  // counts busy cycles from the current drive phase
  task automatic busy_len(input string nm, input int expv);
    int n;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      step();
    end
    chk(nm, n, expv);
  endtask

  initial begin
    int nb;
    rst_n = 0; cen = 1; clr = 0; rfp_op = RFP_NONE; rfp_in = 0;
    we = 0; wa = 0; wrel = 0; wsize = 0; wd = 0;
    ra = 0; rrel = 0; rsize = 0; rsex = 0;

    tbl[0]  = '{mk(0,1,1,0), SZ_LONG, 1'b0, 32'h12345678};
    tbl[1]  = '{mk(0,1,1,2), SZ_BYTE, 1'b0, 32'h00000034};
    tbl[2]  = '{mk(0,1,1,3), SZ_BYTE, 1'b1, 32'h00000012};
    tbl[3]  = '{mk(0,1,1,1), SZ_WORD, 1'b1, 32'h00005678};
    tbl[4]  = '{mk(0,1,1,3), SZ_WORD, 1'b0, 32'h00001234};
    tbl[5]  = '{mk(0,2,3,1), SZ_BYTE, 1'b1, 32'hFFFFFFFF};
    tbl[6]  = '{mk(0,2,3,1), SZ_WORD, 1'b1, 32'hFFFFFF80};
    tbl[7]  = '{mk(0,2,3,0), SZ_LONG, 1'b0, 32'h0000FF80};
    tbl[8]  = '{mk(1,0,1,0), SZ_LONG, 1'b0, 32'hCAFEF00D};
    tbl[9]  = '{mk(1,0,1,3), SZ_BYTE, 1'b0, 32'h000000CA};
    tbl[10] = '{mk(0,3,0,0), SZ_LONG, 1'b0, 32'h00002211};
    tbl[11] = '{mk(0,3,1,0), SZ_LONG, 1'b0, 32'h0BADF00D};
    tbl[12] = '{mk(0,3,1,2), 2'd3,    1'b0, 32'h0BADF00D};
    tbl[13] = '{mk(0,0,0,0), SZ_LONG, 1'b0, 32'h00000000};
    tbl[14] = '{mk(0,2,3,0), SZ_BYTE, 1'b1, 32'hFFFFFF80};

    // reset state
    repeat (2) @(posedge clk);
    rd_req(0, mk(0,1,1,0), 0, SZ_LONG, 0, 0, "rst_rd0");
    rd_req(1, mk(1,0,3,0), 0, SZ_LONG, 0, 0, "rst_rd1");
    rd_chk();
    chk("rst_busy", busy, 1);
    chk("rst_rfp", rfp, 0);
    chk("rst_drop", wr_drop, 0);

    // post-reset clear, with a write during busy
    step();
    rst_n = 1;
    rd_req(0, mk(0,0,0,0), 0, SZ_LONG, 0, 0, "busy_rd");
    nb = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) wr(mk(0,0,0,0), 0, SZ_LONG, 32'hDEADBEEF);
      else we = 0;
      if (c == 0) rd_chk();
      else @(negedge clk);
      if (c == 1) chk("drop_pulse", wr_drop, 1);
      if (c == 2) chk("drop_end", wr_drop, 0);
      if (!busy) break;
      nb++;
      step();
    end
    chk("busy_len_rst", nb, 20);

    // long write, same-cycle and bypass reads
    step();
    wr(mk(0,1,1,0), 0, SZ_LONG, 32'h12345678);
    rd_req(0, mk(0,1,1,0), 0, SZ_LONG, 0, 0, "pre_write");
    rd_chk();
    step();
    we = 0;
    rd_req(0, mk(0,1,1,0), 0, SZ_LONG, 0, 32'h12345678, "byp_long");
    rd_req(1, mk(0,1,1,2), 0, SZ_WORD, 1, 32'h00001234, "byp_word");
    rd_chk();
    step();
    wr(mk(0,2,3,0), 0, SZ_BYTE, 32'h80);
    rd_req(1, mk(0,1,1,2), 0, SZ_BYTE, 0, 32'h34, "arr_byte");
    rd_chk();
    step();
    wr(mk(0,2,3,1), 0, SZ_BYTE, 32'hFF);
    step();
    wr(mk(1,2,1,0), 0, SZ_LONG, 32'hCAFEF00D);
    rd_req(0, mk(0,2,3,0), 0, SZ_LONG, 0, 32'h0000FF80, "b2b_long");
    rd_req(1, mk(0,2,3,0), 0, SZ_BYTE, 1, 32'hFFFFFF80, "b2b_sex");
    rd_chk();
    step();
    wr(mk(0,3,0,0), 0, SZ_WORD, 32'h00AB1111);
    step();
    wr(mk(0,3,0,1), 0, SZ_BYTE, 32'h22);
    step();
    wr(mk(0,3,1,2), 0, 2'd3, 32'h0BADF00D);
    step();
    we = 0;
    step();

    // table of reads against settled contents
    for (int i = 0; i < 15; i++) begin
      int j;
      j = (i + 1) % 15;
      rd_req(0, tbl[i].a, 0, tbl[i].sz, tbl[i].sx,
             tbl[i].exp, $sformatf("tbl_p0_%0d", i));
      rd_req(1, tbl[j].a, 0, tbl[j].sz, tbl[j].sx,
             tbl[j].exp, $sformatf("tbl_p1_%0d", j));
      rd_chk();
      step();
    end

    // bank pointer wrap and relative addressing
    rfp_op = RFP_DECF;
    step();
    rfp_op = RFP_INCF;
    @(negedge clk);
    chk("rfp_decf_wrap", rfp, 3);
    step();
    rfp_op = RFP_INCF;
    wr(mk(0,3,2,0), 1, SZ_LONG, 32'hAA);
    @(negedge clk);
    chk("rfp_incf_wrap", rfp, 0);
    step();
    rfp_op = RFP_NONE;
    we = 0;
    wrel = 0;
    rd_req(0, mk(0,0,2,0), 0, SZ_LONG, 0, 32'hAA, "rel_bank0");
    rd_req(1, mk(0,2,2,0), 1, SZ_LONG, 0, 0, "rel_bank1");
    rd_chk();
    chk("rfp_incf", rfp, 1);
    step();
    rfp_op = RFP_LD;
    rfp_in = 0;
    rd_req(1, mk(0,2,2,0), 1, SZ_LONG, 0, 0, "rel_old");
    rd_chk();
    step();
    rfp_op = RFP_NONE;
    rd_req(1, mk(0,2,2,0), 1, SZ_LONG, 0, 32'hAA, "rel_ld");
    rd_req(0, mk(1,0,1,0), 1, SZ_LONG, 0, 32'hCAFEF00D, "rel_ptr");
    rd_chk();
    chk("rfp_ld", rfp, 0);

    // clr mid-write, then restart at cnt=5
    step();
    rrel = 0;
    wr(mk(1,0,3,0), 0, SZ_LONG, 32'h00006C00);
    step();
    we = 0;
    clr = 1;
    rd_req(0, mk(1,0,3,0), 0, SZ_LONG, 0, 32'h00006C00, "xsp_byp");
    rd_chk();
    step();
    clr = 0;
    rd_req(0, mk(1,0,3,0), 0, SZ_LONG, 0, 0, "xsp_busy");
    rd_chk();
    chk("clr_busy", busy, 1);
    repeat (5) step();
    clr = 1;
    step();
    clr = 0;
    busy_len("busy_len_restart", 20);
    step();
    rd_req(0, mk(1,0,3,0), 0, SZ_LONG, 0, 0, "xsp_cleared");
    rd_req(1, mk(0,1,1,0), 0, SZ_LONG, 0, 0, "acc_cleared");
    rd_chk();

    // async reset with a write pending
    step();
    wr(mk(0,1,0,0), 0, SZ_LONG, 32'h55AA55AA);
    step();
    we = 0;
    rd_req(0, mk(0,1,0,0), 0, SZ_LONG, 0, 32'h55AA55AA, "pre_rst_byp");
    rd_chk();
    #1 rst_n = 0;
    #1 chk("async_rst_busy", busy, 1);
    step();
    step();
    rst_n = 1;
    busy_len("busy_len_rst2", 20);
    step();
    rd_req(0, mk(0,1,0,0), 0, SZ_LONG, 0, 0, "rst_discard");
    rd_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
